// File: rtl/led7seg_pkg.sv
// Shared constants for the 7-segment scanner: register map, CTRL bit positions
// and the active-high hex decode table.
package led7seg_pkg;

  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrData   = 3'd1;
  localparam logic [2:0] AddrDp     = 3'd2;
  localparam logic [2:0] AddrBlink  = 3'd3;
  localparam logic [2:0] AddrRaw0   = 3'd4;
  localparam logic [2:0] AddrRaw1   = 3'd5;
  localparam logic [2:0] AddrStatus = 3'd7;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlDecodeBit = 1;
  localparam int unsigned CtrlBlinkBit  = 2;
  localparam int unsigned CtrlBrightLsb = 8;

  localparam logic [3:0] BrightReset = 4'hF;

  // Returns {dp,g,f,e,d,c,b,a}, 1 = segment lit.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib, input logic dp);
    logic [6:0] s;
    s = '0;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return {dp, s};
  endfunction

endpackage

// File: rtl/led7seg_scanner_if.sv
// Avalon-MM slave port bundle of the 7-segment scanner.
interface led7seg_scanner_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led7seg_scan_timer.sv
// Scan timebase: sub-slot, PWM step, digit index, frame count and blink phase.
// Everything is held at zero while disabled so re-enabling starts at digit 0.
module led7seg_scan_timer #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SUB_DIV      = 64,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable_i,
  output logic [2:0] dig_idx_o,
  output logic [3:0] pwm_cnt_o,
  output logic       phase_o
);

  localparam int unsigned SubW   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SubW-1:0]   SubMax   = SubW'(SUB_DIV - 1);
  localparam logic [FrameW-1:0] FrameMax = FrameW'(BLINK_FRAMES - 1);
  localparam logic [2:0]        DigMax   = 3'(DIGITS - 1);

  logic [SubW-1:0]   sub_q, sub_d;
  logic [3:0]        pwm_q, pwm_d;
  logic [2:0]        dig_q, dig_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic              phase_q, phase_d;
  logic              sub_wrap, pwm_wrap, dig_wrap;

  assign sub_wrap = (sub_q == SubMax);
  assign pwm_wrap = sub_wrap && (pwm_q == 4'hF);
  assign dig_wrap = pwm_wrap && (dig_q == DigMax);

  always_comb begin
    sub_d   = sub_q;
    pwm_d   = pwm_q;
    dig_d   = dig_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (!enable_i) begin
      sub_d   = '0;
      pwm_d   = '0;
      dig_d   = '0;
      frame_d = '0;
      phase_d = 1'b0;
    end else begin
      sub_d = sub_wrap ? '0 : sub_q + SubW'(1);
      if (sub_wrap) pwm_d = pwm_q + 4'd1;
      if (pwm_wrap) dig_d = dig_wrap ? 3'd0 : dig_q + 3'd1;
      if (dig_wrap) begin
        if (frame_q == FrameMax) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + FrameW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_q   <= '0;
      pwm_q   <= '0;
      dig_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      sub_q   <= sub_d;
      pwm_q   <= pwm_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end

  assign dig_idx_o = dig_q;
  assign pwm_cnt_o = pwm_q;
  assign phase_o   = phase_q;

endmodule

// File: rtl/led7seg_scanner.sv
// Multiplexed 7-segment display driver: register file, read mux, pattern select
// and registered, polarity-adjusted segment/digit outputs.
module led7seg_scanner
  import led7seg_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SUB_DIV        = 64,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  led7seg_scanner_if.slave  bus,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] dig
);

  localparam int unsigned IdxW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned Raw0N = (DIGITS < 4) ? DIGITS : 4;
  localparam logic [7:0]        SegOff = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DigOff = {DIGITS{DIG_ACTIVE_LOW}};

  logic                       enable_q, enable_d;
  logic                       decode_q, decode_d;
  logic                       blink_en_q, blink_en_d;
  logic [3:0]                 bright_q, bright_d;
  logic [DIGITS-1:0][3:0]     data_q, data_d;
  logic [DIGITS-1:0]          dp_q, dp_d;
  logic [DIGITS-1:0]          blink_q, blink_d;
  logic [DIGITS-1:0][7:0]     raw_q, raw_d;
  logic [7:0]                 seg_q, seg_d;
  logic [DIGITS-1:0]          dig_q, dig_d;

  logic [2:0]        dig_idx;
  logic [3:0]        pwm_cnt;
  logic              phase;
  logic [IdxW-1:0]   idx;
  logic              wr_en;
  logic              lit;
  logic [7:0]        pattern;
  logic [31:0]       rdata;

  led7seg_scan_timer #(
    .DIGITS       (DIGITS),
    .SUB_DIV      (SUB_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable_i  (enable_q),
    .dig_idx_o (dig_idx),
    .pwm_cnt_o (pwm_cnt),
    .phase_o   (phase)
  );

  assign wr_en = bus.chipselect && !bus.write_n;
  assign idx   = dig_idx[IdxW-1:0];

  always_comb begin
    enable_d   = enable_q;
    decode_d   = decode_q;
    blink_en_d = blink_en_q;
    bright_d   = bright_q;
    data_d     = data_q;
    dp_d       = dp_q;
    blink_d    = blink_q;
    raw_d      = raw_q;
    if (wr_en) begin
      case (bus.address)
        AddrCtrl: begin
          enable_d   = bus.writedata[CtrlEnableBit];
          decode_d   = bus.writedata[CtrlDecodeBit];
          blink_en_d = bus.writedata[CtrlBlinkBit];
          bright_d   = bus.writedata[CtrlBrightLsb +: 4];
        end
        AddrData:  data_d  = bus.writedata[4*DIGITS-1:0];
        AddrDp:    dp_d    = bus.writedata[DIGITS-1:0];
        AddrBlink: blink_d = bus.writedata[DIGITS-1:0];
        AddrRaw0: begin
          for (int i = 0; i < Raw0N; i++) raw_d[i] = bus.writedata[8*i +: 8];
        end
        AddrRaw1: begin
          for (int i = 4; i < DIGITS; i++) raw_d[i] = bus.writedata[8*(i-4) +: 8];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      AddrCtrl: begin
        rdata[CtrlEnableBit]      = enable_q;
        rdata[CtrlDecodeBit]      = decode_q;
        rdata[CtrlBlinkBit]       = blink_en_q;
        rdata[CtrlBrightLsb +: 4] = bright_q;
      end
      AddrData:  rdata[4*DIGITS-1:0] = data_q;
      AddrDp:    rdata[DIGITS-1:0]   = dp_q;
      AddrBlink: rdata[DIGITS-1:0]   = blink_q;
      AddrRaw0: begin
        for (int i = 0; i < Raw0N; i++) rdata[8*i +: 8] = raw_q[i];
      end
      AddrRaw1: begin
        for (int i = 4; i < DIGITS; i++) rdata[8*(i-4) +: 8] = raw_q[i];
      end
      AddrStatus: begin
        rdata[2:0] = dig_idx;
        rdata[8]   = phase;
      end
      default: ;
    endcase
  end

  assign bus.readdata = rdata;

  // Active-high pattern first; polarity is folded in just before the output flops.
  always_comb begin
    lit     = enable_q && (pwm_cnt <= bright_q) && !(blink_en_q && phase && blink_q[idx]);
    pattern = decode_q ? hex_to_seg(data_q[idx], dp_q[idx]) : raw_q[idx];
    seg_d   = (lit ? pattern : 8'h00) ^ SegOff;
    dig_d   = (lit ? (DIGITS'(1) << idx) : '0) ^ DigOff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= 1'b1;
      decode_q   <= 1'b1;
      blink_en_q <= 1'b0;
      bright_q   <= BrightReset;
      data_q     <= '0;
      dp_q       <= '0;
      blink_q    <= '0;
      raw_q      <= '0;
      seg_q      <= SegOff;
      dig_q      <= DigOff;
    end else begin
      enable_q   <= enable_d;
      decode_q   <= decode_d;
      blink_en_q <= blink_en_d;
      bright_q   <= bright_d;
      data_q     <= data_d;
      dp_q       <= dp_d;
      blink_q    <= blink_d;
      raw_q      <= raw_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

endmodule

// File: tb/tb_led7seg_scanner.sv
// Directed bench for led7seg_scanner: 4 digits, 32-cycle slots, 2-frame blink half-period.
module tb_led7seg_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] seg;
  logic [3:0] dig;
  int         checks = 0;
  int         errors = 0;
  logic [31:0] rd;

  // Expected active-low seg per digit for the decode and raw scenarios.
  logic [7:0] dec_seg [4] = '{8'hF9, 8'h46, 8'h99, 8'h88};
  logic [7:0] raw_seg [4] = '{8'h7F, 8'hF9, 8'hC0, 8'h80};

  led7seg_scanner_if bus ();

  led7seg_scanner #(
    .DIGITS         (4),
    .SUB_DIV        (2),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .seg     (seg),
    .dig     (dig)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    data = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] exp_dig, input logic [7:0] exp_seg);
    check_eq({tag, "_dig"}, {28'd0, dig}, {28'd0, exp_dig});
    check_eq({tag, "_seg"}, {24'd0, seg}, {24'd0, exp_seg});
  endtask

  initial begin
    int lit_cnt;
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;

    // Reset
    #12;
    check_out("in_reset", 4'hF, 8'hFF);
    bus_read(3'd0, rd); check_eq("rst_ctrl", rd, 32'h0000_0F03);
    bus_read(3'd1, rd); check_eq("rst_data", rd, 32'h0);
    bus_read(3'd2, rd); check_eq("rst_dp", rd, 32'h0);
    bus_read(3'd3, rd); check_eq("rst_blink", rd, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    check_out("first_edge", 4'hE, 8'hC0);

    // Disable, register width and unused address
    bus_write(3'd0, 32'h0000_0F02);
    step(1);
    check_out("disabled", 4'hF, 8'hFF);
    bus_read(3'd7, rd); check_eq("disabled_status", rd, 32'h0);
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_read(3'd2, rd); check_eq("dp_width", rd, 32'h0000_000F);
    bus_write(3'd6, 32'h1234_5678);
    bus_read(3'd6, rd); check_eq("unused_addr", rd, 32'h0);

    // Decode
    bus_write(3'd1, 32'h0000_A4C1);
    bus_write(3'd2, 32'h0000_0002);
    bus_write(3'd0, 32'h0000_0F03);
    step(6);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step(32);
      check_out($sformatf("decode_d%0d", d), 4'hF ^ (4'h1 << d), dec_seg[d]);
    end

    // Raw and wrap
    bus_write(3'd0, 32'h0000_0F00);
    bus_write(3'd4, 32'h7F3F_0680);
    bus_write(3'd0, 32'h0000_0F01);
    step(6);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) step(32);
      check_out($sformatf("raw_d%0d", d), 4'hF ^ (4'h1 << d), raw_seg[d]);
    end
    bus_read(3'd7, rd); check_eq("raw_status_last", rd, 32'h3);
    step(32);
    check_out("raw_wrap", 4'hE, 8'h7F);
    bus_read(3'd7, rd); check_eq("raw_status_wrap", rd, 32'h0);

    // Brightness 3: sub-slots 0..3 lit, i.e. 8 of 32 cycles
    bus_write(3'd0, 32'h0000_0302);
    bus_write(3'd0, 32'h0000_0303);
    step(32);
    lit_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (dig != 4'hF) lit_cnt++;
      if (i == 7) check_out("bright_last_lit", 4'hD, 8'h46);
      if (i == 8) check_out("bright_first_dark", 4'hF, 8'hFF);
    end
    check_eq("bright_duty", lit_cnt, 32'd8);

    // Blink digit 0
    bus_write(3'd0, 32'h0000_0F06);
    bus_write(3'd3, 32'h0000_0001);
    bus_write(3'd0, 32'h0000_0F07);
    step(6);
    check_out("blink_on_d0", 4'hE, 8'hF9);
    step(249);
    bus_read(3'd7, rd); check_eq("blink_phase0", rd & 32'h100, 32'h0);
    step(1);
    bus_read(3'd7, rd); check_eq("blink_phase1", rd & 32'h100, 32'h100);
    step(6);
    check_out("blink_off_d0", 4'hF, 8'hFF);
    step(32);
    check_out("blink_d1", 4'hD, 8'h46);
    step(224);
    check_out("blink_back_d0", 4'hE, 8'hF9);

    // Enable and reset mid-scan
    bus_write(3'd0, 32'h0000_0F03);
    step(10);
    bus_write(3'd0, 32'h0000_0F02);
    step(1);
    check_out("midslot_disable", 4'hF, 8'hFF);
    bus_read(3'd7, rd); check_eq("midslot_status", rd, 32'h0);
    bus_write(3'd0, 32'h0000_0F03);
    step(1);
    check_out("reenable", 4'hE, 8'hF9);
    step(10);
    check_out("reenable_run", 4'hE, 8'hF9);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_reset", 4'hF, 8'hFF);
    bus_read(3'd1, rd); check_eq("async_reset_data", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led7seg_scanner.md
# led7seg_scanner

Avalon-MM slave that drives a multiplexed common-anode/cathode 7-segment display of up to 8 digits. It is the parametrised successor to the static 24-bit segment PIO. Software writes hex nibbles or raw segment bytes; the block scans the digits, decodes hex, and applies per-digit decimal points, 16-step brightness PWM and per-digit blinking. It sits on the Nios II data master's peripheral bridge and drives the board display pins directly.

## Interface
- DIGITS, 4: number of digits, 1..8.
- SUB_DIV, 64: clock cycles per PWM sub-slot. One digit slot is 16 sub-slots, i.e. 16*SUB_DIV cycles. Must be >= 1.
- BLINK_FRAMES, 64: full scan frames per blink half-period. Must be >= 1.
- SEG_ACTIVE_LOW, 1: 1 means segment lit = 0.
- DIG_ACTIVE_LOW, 1: 1 means digit selected = 0.

Ports (clock and reset first):
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous, active-low reset.
- address, in, 3: register word address.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe.
- writedata, in, 32: write data.
- readdata, out, 32: read data, combinational, zero wait/latency.
- seg, out, 8: {dp,g,f,e,d,c,b,a}; bit0 = a.
- dig, out, DIGITS: one-hot digit select; bit i = digit i.

## Operation
- A write occurs when chipselect=1 and write_n=0. Register bits above the implemented width are ignored on write and read as 0. Unused addresses read 0 and ignore writes.
- Register map:
  - 0 CTRL: [0] enable, [1] decode (1 = hex, 0 = raw), [2] blink_en, [11:8] bright. Reset value 0x0F03.
  - 1 DATA: nibble i at [4i+3:4i] is the hex value of digit i. Reset 0.
  - 2 DP: [DIGITS-1:0] decimal point per digit, used in decode mode only. Reset 0.
  - 3 BLINK: [DIGITS-1:0] blink mask. Reset 0.
  - 4 RAW0: bytes for digits 0..3. Reset 0.
  - 5 RAW1: bytes for digits 4..7. Reset 0.
  - 7 STATUS (read-only): [2:0] current digit index, [8] blink phase.
- Counters:
  - sub_cnt runs 0..SUB_DIV-1.
  - pwm_cnt is 4 bits and advances when sub_cnt wraps.
  - dig_idx advances when pwm_cnt wraps 15→0. It runs 0..DIGITS-1 and then returns to 0.
  - frame_cnt counts dig_idx wraps. At BLINK_FRAMES-1 it resets to 0 and toggles blink phase.
- Segment pattern for dig_idx:
  - Decode mode: hex_to_seg(DATA nibble) with dp = DP[dig_idx].
  - Raw mode: the RAW byte taken as-is.
- Lit condition: enable=1, pwm_cnt <= bright, and not (blink_en && phase && BLINK[dig_idx]).
  - When lit, seg and dig are driven to the pattern / one-hot index.
  - When not lit, all segments and digits are inactive.
- Polarity is applied last, via the SEG/DIG_ACTIVE_LOW parameters.
- enable=0:
  - All counters and the blink phase are held at 0, and the outputs are inactive.
  - Setting enable=1 restarts scanning at digit 0, sub-slot 0.
- Hex decode table, lit segments:
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc.
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.

## Timing
- Reset: seg = all inactive (0xFF when SEG_ACTIVE_LOW), dig = all inactive. All counters are 0 and the blink phase is 0.
- seg and dig are registered; they show the state of the counters/registers one cycle later.
  - The first clock edge after reset release drives digit 0, lit at full brightness.
- Register writes take effect on the write edge. The outputs reflect them on the next edge. There is no slot-boundary synchronisation (tearing mid-slot is accepted).
- Read of a register in the same cycle as a write to it returns the old value.
- Reset asserted mid-scan forces the outputs inactive immediately (asynchronously).
- bright=15 gives 100% duty. bright=0 gives 1/16 duty (one sub-slot per slot).

## Structure
- Package led7seg_pkg holds:
  - the register address constants (CTRL..STATUS);
  - the CTRL bit positions;
  - the hex_to_seg function returning active-high {dp,g..a}.
- One sub-module, led7seg_scan_timer, holds sub_cnt/pwm_cnt/dig_idx/frame_cnt/phase. It has inputs enable and parameters, and outputs dig_idx, pwm_cnt and phase.
- The top level contains the register file, the readdata mux, the pattern select and the output registers.

## Test plan
All scenarios use DIGITS=4, SUB_DIV=2 (32-cycle slot) and BLINK_FRAMES=2.
- Reset: during and after reset_n=0 → seg=0xFF, dig=0xF. Reading CTRL returns 0x00000F03. Reading DATA, DP and BLINK returns 0.
- Decode: write DATA=0x0000A4C1, DP=0x2 → across slots, dig cycles 0xE,0xD,0xB,0x7 (active-low). seg per digit is ~0x06, ~0xB9, ~0x66, ~0x77. Digit 1 has dp lit, i.e. seg=0x46.
- Raw/wrap: CTRL=0x0F01, RAW0=0x7F3F0680 → seg = ~0x80, ~0x06, ~0x3F, ~0x7F on digits 0..3. The sequence returns to digit 0 after 128 cycles. STATUS[2:0] is 3 during the last slot.
- Brightness: CTRL=0x0303 → in each slot, dig is active for 8 cycles (sub-slots 0..3) and inactive for 24.
- Blink: CTRL=0x0F07, BLINK=0x1 → digit 0 is lit for frames 0–1 and dark for frames 2–3 (cycles 256–511). STATUS[8] toggles at cycle 256. Digits 1–3 are unaffected.
- Enable/reset mid-scan:
  - A write of CTRL=0x0F02 mid-slot gives outputs inactive on the next edge and STATUS=0.
  - Re-enabling drives digit 0 on the next edge.
  - Asserting reset_n mid-slot makes the outputs inactive without waiting for a clock edge.
